e_output_arbiter: RTL and testbench

- Per-output-port wormhole arbiter in the router arbiter stage.
- Each input buffer has a next-hop register that holds a 3-bit output-port address.
- This block picks one input whose next-hop equals PORT_ID, locks the output to it until the tail flit passes, then rotates priority round-robin.
- Drives the input-buffer read strobes and the output write strobe.

---
 rtl/e_output_arbiter.sv | 174 +++++++++++++++++
 tb/tb_e_output_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/e_output_arbiter.sv
// -----------------------------------------------------------------------------
// e_output_arbiter
//
// Per-output-port wormhole arbiter for the router arbiter stage. Every input
// buffer carries a 3-bit next-hop address. This instance serves output PORT_ID.
// While idle it picks one requesting input round-robin. It then locks the
// output to that input until the tail flit has been transferred. Priority then
// rotates to the input after the one just served.
//
// Parameters
//   NUM_IN   number of competing input buffers (2..8)
//   PORT_ID  output-port address served by this instance
//   CNT_W    width of the optional forwarded-packet counter
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   ib_empty_i     per-input buffer empty flag
//   ib_tail_i      per-input "head flit is a tail" flag
//   nhr_address_i  per-input next-hop address, input i at [3i+2:3i]
//   ob_full_i      downstream output buffer full (stalls transfers)
//   grant_o        registered one-hot grant, zero when idle
//   ib_read_o      combinational pop strobe towards the input buffers
//   ob_write_o     combinational push strobe towards the output buffer
//   busy_o         registered, high while the output is locked to an input
//   pkt_count_o    tail transfers seen, modulo 2^CNT_W
//                  (only when ARB_PKT_CNT_EN is defined)
//
// Build option
//   ARB_PKT_CNT_EN  when defined, adds pkt_count_o and its counter
// -----------------------------------------------------------------------------
module e_output_arbiter #(
  parameter int         NUM_IN  = 5,
  parameter logic [2:0] PORT_ID = 3'b000,
  parameter int         CNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IN-1:0]   ib_empty_i,
  input  logic [NUM_IN-1:0]   ib_tail_i,
  input  logic [3*NUM_IN-1:0] nhr_address_i,
  input  logic                ob_full_i,
  output logic [NUM_IN-1:0]   grant_o,
  output logic [NUM_IN-1:0]   ib_read_o,
  output logic                ob_write_o,
  output logic                busy_o
`ifdef ARB_PKT_CNT_EN
  ,
  output logic [CNT_W-1:0]    pkt_count_o
`endif
);

  localparam int               PTR_W = $clog2(NUM_IN);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_IN - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  rr_ptr_nxt;
  logic [PTR_W-1:0]  owner;
  logic [PTR_W-1:0]  owner_nxt;
  logic [NUM_IN-1:0] grant_nxt;
  logic [NUM_IN-1:0] req;
  logic              sel_vld;
  logic [PTR_W-1:0]  sel_idx;
  logic              xfer;
  logic              tail_xfer;

  // The first requester found when scanning circularly from ptr.
  // The MSB of the result flags that some input was requesting.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_IN-1:0] r,
                                             input logic [PTR_W-1:0]  ptr);
    logic             found;
    logic [PTR_W-1:0] idx;
    int               cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = (int'(ptr) + k) % NUM_IN;
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = PTR_W'(cand);
      end
    end
    return {found, idx};
  endfunction

  // Request decode: an input competes only if it holds a flit bound for us.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      req[i] = !ib_empty_i[i] && (nhr_address_i[3*i +: 3] == PORT_ID);
    end
  end

  assign {sel_vld, sel_idx} = rr_pick(req, rr_ptr);

  // While locked, only the owner's empty/tail flags matter. The grant is
  // one-hot, so masking with it selects the owner without an index mux.
  // Requests and next-hop changes are ignored while locked.
  assign xfer       = (state == LOCKED) && |(grant_o & ~ib_empty_i) && !ob_full_i;
  assign tail_xfer  = xfer && |(grant_o & ib_tail_i);
  assign ib_read_o  = xfer ? grant_o : '0;
  assign ob_write_o = xfer;
  assign busy_o     = (state == LOCKED);

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_o;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          state_nxt = LOCKED;
          owner_nxt = sel_idx;
          grant_nxt = NUM_IN'(1) << sel_idx;
        end
      end
      LOCKED: begin
        // Release only after the tail actually moves. A stall on an empty
        // buffer or a full output holds the lock.
        if (tail_xfer) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          rr_ptr_nxt = (owner == LAST) ? '0 : owner + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      grant_o <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      owner   <= owner_nxt;
      grant_o <= grant_nxt;
    end
  end

`ifdef ARB_PKT_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count_o <= '0;
    end else if (tail_xfer) begin
      pkt_count_o <= pkt_count_o + 1'b1;
    end
  end
`endif

  a_grant_onehot : assert property (@(posedge clk) disable iff (!reset)
    $onehot0(grant_o));

  a_idle_quiet : assert property (@(posedge clk) disable iff (!reset)
    (state == IDLE) |-> (ib_read_o == '0 && !ob_write_o));

  a_busy_grant : assert property (@(posedge clk) disable iff (!reset)
    busy_o == (grant_o != '0));

endmodule

// File: tb/tb_e_output_arbiter.sv
module tb_e_output_arbiter;
  localparam int         N   = 5;
  localparam logic [2:0] PID = 3'b000;
  localparam int         CW  = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   ib_empty;
  logic [N-1:0]   ib_tail;
  logic [3*N-1:0] nhr;
  logic           ob_full;
  logic [N-1:0]   grant;
  logic [N-1:0]   ib_read;
  logic           ob_write;
  logic           busy;
`ifdef ARB_PKT_CNT_EN
  logic [CW-1:0]  pkt_count;
  int             seq [5] = '{1, 2, 3, 0, 1};
`endif

  e_output_arbiter #(.NUM_IN(N), .PORT_ID(PID), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .ib_empty_i    (ib_empty),
    .ib_tail_i     (ib_tail),
    .nhr_address_i (nhr),
    .ob_full_i     (ob_full),
    .grant_o       (grant),
    .ib_read_o     (ib_read),
    .ob_write_o    (ob_write),
    .busy_o        (busy)
`ifdef ARB_PKT_CNT_EN
    ,
    .pkt_count_o   (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which input owns the output (if any), whose turn is
  // next, and how many packets have been forwarded.
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_pkts;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit wants(input int i);
    return !ib_empty[i] && (nhr[3*i +: 3] == PID);
  endfunction

  // Called at a negedge with inputs already set. It checks all outputs
  // against the model, then advances the model across one rising edge.
  task automatic step(input string tag);
    bit xf;
    #1;
    xf = m_locked && !ib_empty[m_owner] && !ob_full;
    chk({tag, ":grant"}, grant, m_locked ? (32'd1 << m_owner) : 32'd0);
    chk({tag, ":busy"},  busy, m_locked ? 32'd1 : 32'd0);
    chk({tag, ":read"},  ib_read, xf ? (32'd1 << m_owner) : 32'd0);
    chk({tag, ":write"}, ob_write, xf ? 32'd1 : 32'd0);
`ifdef ARB_PKT_CNT_EN
    chk({tag, ":cnt"}, pkt_count, m_pkts % (1 << CW));
`endif
    @(posedge clk);
    if (m_locked) begin
      if (xf && ib_tail[m_owner]) begin
        m_locked = 1'b0;
        m_ptr    = (m_owner + 1) % N;
        m_pkts++;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (wants(i)) begin
          m_locked = 1'b1;
          m_owner  = i;
          break;
        end
      end
    end
    @(negedge clk);
  endtask

  // Asserted at a negedge, so the outputs must clear without any clock edge.
  task automatic apply_reset(input string tag);
    reset = 1'b0;
    #1;
    chk({tag, ":grant"}, grant, 32'd0);
    chk({tag, ":busy"},  busy, 32'd0);
    chk({tag, ":read"},  ib_read, 32'd0);
    chk({tag, ":write"}, ob_write, 32'd0);
`ifdef ARB_PKT_CNT_EN
    chk({tag, ":cnt"}, pkt_count, 32'd0);
`endif
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_pkts   = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    ib_empty = '1;
    ib_tail  = '0;
    nhr      = '0;
    ob_full  = 1'b0;
    @(negedge clk);
    apply_reset("rst0");

    // A single requester on input 2 is granted one cycle later.
    ib_empty = 5'b11011;
    step("tp1_arb");
    chk("tp1_grant", grant, 5'b00100);
    chk("tp1_busy", busy, 1);
    ib_tail = 5'b00100;
    step("tp1_tail");
    ib_empty = '1;
    ib_tail  = '0;
    step("tp1_idle");
    apply_reset("rst1");

    // Inputs 1 and 3 with 2-flit packets. Input 1 goes first, input 3 is
    // granted two cycles after input 1's tail, and priority moves to 4.
    ib_empty = 5'b10101;
    step("tp2_arb");
    chk("tp2_first", grant, 5'b00010);
    step("tp2_body1");
    ib_tail = 5'b00010;
    step("tp2_tail1");
    chk("tp2_gap", grant, 5'b00000);
    ib_empty = 5'b10111;
    ib_tail  = '0;
    step("tp2_rearb");
    chk("tp2_second", grant, 5'b01000);
    step("tp2_body3");
    ib_tail = 5'b01000;
    step("tp2_tail3");
    ib_empty = 5'b01110;
    ib_tail  = '0;
    step("tp2_ptr");
    chk("tp2_ptr4", grant, 5'b10000);

    // Output full for 3 cycles while locked to input 4.
    ob_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step("tp3_full");
      chk("tp3_hold", grant, 5'b10000);
      chk("tp3_noread", ib_read, 5'b00000);
      chk("tp3_nowrite", ob_write, 0);
    end
    ob_full = 1'b0;
    #1;
    chk("tp3_resume_rd", ib_read, 5'b10000);
    chk("tp3_resume_wr", ob_write, 1);
    step("tp3_body");
    ib_tail = 5'b10000;
    step("tp3_tail");

    // Input 0 runs dry mid-packet while input 1 waits: the lock holds.
    ib_empty = 5'b11100;
    ib_tail  = '0;
    step("tp4_arb");
    chk("tp4_lock", grant, 5'b00001);
    step("tp4_body");
    ib_empty = 5'b11101;
    for (int c = 0; c < 3; c++) begin
      step("tp4_dry");
      chk("tp4_hold", grant, 5'b00001);
    end
    ib_empty = 5'b11100;
    ib_tail  = 5'b00001;
    step("tp4_tail");
    chk("tp4_release", grant, 5'b00000);
    ib_tail = '0;
    step("tp4_next");
    chk("tp4_next1", grant, 5'b00010);
    ib_tail = 5'b00010;
    step("tp4_tail1");

    // Wrong next-hop: no grant. Then an async reset while locked.
    ib_empty  = 5'b11110;
    ib_tail   = '0;
    nhr[2:0]  = 3'b011;
    for (int c = 0; c < 3; c++) begin
      step("tp5_other");
      chk("tp5_nogrant", grant, 5'b00000);
    end
    nhr[2:0] = PID;
    step("tp5_arb");
    chk("tp5_busy", busy, 1);
    apply_reset("tp5_rst");

    // Five single-flit packets. With a 2-bit counter, the count wraps.
    ib_empty = 5'b11110;
    ib_tail  = 5'b00001;
    for (int p = 0; p < 5; p++) begin
      step("cnt_arb");
      step("cnt_tail");
`ifdef ARB_PKT_CNT_EN
      chk("cnt_seq", pkt_count, seq[p]);
`endif
    end

    // Random traffic with occasional resets.
    apply_reset("rnd_rst");
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        ib_empty[i]    = ($urandom_range(0, 3) == 0);
        ib_tail[i]     = ($urandom_range(0, 2) == 0);
        nhr[3*i +: 3]  = ($urandom_range(0, 1) == 0) ? PID : 3'($urandom_range(0, 7));
      end
      ob_full = ($urandom_range(0, 4) == 0);
      if (c % 997 == 996) apply_reset("rnd_rst");
      else step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
